// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Finishes with a multiply-by-1 so the result leaves the Montgomery domain.
module mont_exp_ctrl #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned EXP_WIDTH = 512,
  parameter int unsigned IDX_W     = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_r,
  input  logic [EXP_WIDTH-1:0] i_e,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_mm_start,
  output logic [WIDTH-1:0]     o_mm_a,
  output logic [WIDTH-1:0]     o_mm_b,
  input  logic [WIDTH-1:0]     i_mm_result,
  input  logic                 i_mm_done
);

  typedef enum logic [2:0] {
    StIdle, StSqIssue, StSqWait, StMulIssue, StMulWait, StPostIssue, StPostWait, StDone
  } state_e;

  state_e               r_state;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_a;
  logic [EXP_WIDTH-1:0] r_e;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mm_start;
  logic [WIDTH-1:0]     r_mm_b;
  logic [WIDTH-1:0]     r_result;

  // Operand A is the accumulator itself: it only changes when the next op is issued.
  assign o_mm_a     = r_a;
  assign o_mm_b     = r_mm_b;
  assign o_mm_start = r_mm_start;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_a        <= '0;
      r_e        <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_b     <= '0;
      r_result   <= '0;
    end else begin
      r_mm_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_x        <= i_x;
            r_a        <= i_r;
            r_e        <= i_e;
            r_idx      <= IDX_W'(EXP_WIDTH - 1);
            r_busy     <= 1'b1;
            r_mm_b     <= i_r;
            r_mm_start <= 1'b1;
            r_state    <= StSqIssue;
          end
        end
        StSqIssue: r_state <= StSqWait;
        StSqWait: begin
          if (i_mm_done) begin
            r_a        <= i_mm_result;
            r_mm_start <= 1'b1;
            if (r_e[r_idx]) begin
              r_mm_b  <= r_x;
              r_state <= StMulIssue;
            end else if (r_idx == '0) begin
              r_mm_b  <= WIDTH'(1);
              r_state <= StPostIssue;
            end else begin
              r_mm_b  <= i_mm_result;
              r_idx   <= r_idx - 1'b1;
              r_state <= StSqIssue;
            end
          end
        end
        StMulIssue: r_state <= StMulWait;
        StMulWait: begin
          if (i_mm_done) begin
            r_a        <= i_mm_result;
            r_mm_start <= 1'b1;
            if (r_idx == '0) begin
              r_mm_b  <= WIDTH'(1);
              r_state <= StPostIssue;
            end else begin
              r_mm_b  <= i_mm_result;
              r_idx   <= r_idx - 1'b1;
              r_state <= StSqIssue;
            end
          end
        end
        StPostIssue: r_state <= StPostWait;
        StPostWait: begin
          if (i_mm_done) begin
            r_result <= i_mm_result;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Randomized bench for mont_exp_ctrl with a behavioural Montgomery multiplier (M=13, R=16).
module tb_mont_exp_ctrl;

  localparam int M    = 13;
  localparam int RINV = 9;   // 16^-1 mod 13
  localparam int RMOD = 3;   // 16 mod 13

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] x = '0, r = '0, e = '0;
  logic       busy, done, mm_start;
  logic [3:0] result, mm_a, mm_b;
  logic [3:0] mm_result = '0;
  logic       mdl_done = 1'b0, spur_done = 1'b0;
  logic       mm_done;
  int         mdl_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign mm_done = mdl_done | spur_done;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(4), .EXP_WIDTH(4), .IDX_W(2)) u_dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_x         (x),
    .i_r         (r),
    .i_e         (e),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
    .o_mm_start  (mm_start),
    .o_mm_a      (mm_a),
    .o_mm_b      (mm_b),
    .i_mm_result (mm_result),
    .i_mm_done   (mm_done)
  );

  // Multiplier model: a*b*R^-1 mod M, done pulse 5 cycles after start; ignores DUT reset.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_done <= 1'b1;
    end
    if (mm_start) begin
      mdl_cnt   <= 5;
      mm_result <= 4'((int'(mm_a) * int'(mm_b) * RINV) % M);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mmul(input int a, input int b);
    return (a * b * RINV) % M;
  endfunction

  function automatic int ref_pow(input int b, input int ee);
    int p = 1;
    for (int i = 0; i < ee; i++) p = (p * b) % M;
    return p;
  endfunction

  task automatic run_exp(input string name, input int base, input int ee, input bit poke);
    int xm, acc, cyc, busy_bad, unstable, res;
    int ops_a[$], ops_b[$], exp_a[$], exp_b[$];
    logic [3:0] la, lb;
    bit got_done;
    xm = (base * 16) % M;
    la = '0;
    lb = '0;
    busy_bad = 0;
    unstable = 0;
    res = -1;
    got_done = 1'b0;
    @(negedge clk);
    x = 4'(xm); r = 4'(RMOD); e = 4'(ee); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 4'($urandom); r = 4'($urandom); e = 4'($urandom);
    cyc = 0;
    while (!got_done && cyc < 400) begin
      if (mm_start) begin
        ops_a.push_back(int'(mm_a));
        ops_b.push_back(int'(mm_b));
        la = mm_a;
        lb = mm_b;
      end else if (mdl_cnt != 0 && (mm_a != la || mm_b != lb)) begin
        unstable++;
      end
      if (done) begin
        got_done = 1'b1;
        res = int'(result);
        chk({name, "_busy_in_done"}, int'(busy), 0);
      end else if (!busy) begin
        busy_bad++;
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
        start = poke && (cyc == 2);
        if (start) begin
          x = 4'($urandom); r = 4'($urandom); e = 4'($urandom);
        end
      end
    end
    chk({name, "_done_seen"}, int'(got_done), 1);
    @(negedge clk);
    chk({name, "_done_pulse"}, int'(done), 0);
    chk({name, "_result_held"}, int'(result), res);

    acc = RMOD;
    for (int i = 3; i >= 0; i--) begin
      exp_a.push_back(acc); exp_b.push_back(acc);
      acc = mmul(acc, acc);
      if (((ee >> i) & 1) == 1) begin
        exp_a.push_back(acc); exp_b.push_back(xm);
        acc = mmul(acc, xm);
      end
    end
    exp_a.push_back(acc); exp_b.push_back(1);

    chk({name, "_op_count"}, ops_a.size(), exp_a.size());
    for (int i = 0; i < ops_a.size() && i < exp_a.size(); i++) begin
      chk($sformatf("%s_op%0d_a", name, i), ops_a[i], exp_a[i]);
      chk($sformatf("%s_op%0d_b", name, i), ops_b[i], exp_b[i]);
    end
    chk({name, "_result"}, res, ref_pow(base, ee));
    chk({name, "_busy"}, busy_bad, 0);
    chk({name, "_stable"}, unstable, 0);
  endtask

  initial begin
    int n, cyc, bad;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mm_start", int'(mm_start), 0);
    chk("rst_mm_a", int'(mm_a), 0);
    chk("rst_mm_b", int'(mm_b), 0);
    chk("rst_result", int'(result), 0);
    reset = 1'b0;

    // Spurious mm_done while idle must not start anything.
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    bad = 0;
    repeat (3) begin
      if (busy || mm_start || done) bad++;
      @(negedge clk);
    end
    chk("spur_idle", bad, 0);

    run_exp("basic", 2, 5, 1'b1);
    run_exp("zero_e", 2, 0, 1'b0);
    run_exp("ones", 2, 15, 1'b0);

    // Abort during the second multiply wait.
    @(negedge clk);
    x = 4'd6; r = 4'(RMOD); e = 4'b0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 200) begin
      if (mm_start) n++;
      if (n < 6) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_reach_mul2", n, 6);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_mm_start", int'(mm_start), 0);
    chk("midrst_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || mm_start || done) bad++;
    end
    chk("stale_ignored", bad, 0);
    run_exp("after_rst", 2, 5, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_exp($sformatf("rnd%0d", k), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
